// File: rtl/mmio_uart_tx_pkg.sv
// mmio_uart_tx_pkg
// Shared constants and types for the memory-mapped UART transmitter:
//   - bus widths of the CPU data-memory port
//   - register offsets inside the 16-byte window (addr[3:2])
//   - serializer state encoding
//   - packStatus() builds the STATUS read word
package mmio_uart_tx_pkg;

   localparam int MemAddrWidth = 32;
   localparam int RegDataWidth = 32;

   localparam logic [1:0] UartTxDataOff = 2'd0;
   localparam logic [1:0] UartStatusOff = 2'd1;
   localparam logic [1:0] UartDivOff    = 2'd2;

   typedef enum logic [1:0] {
      UartIdle  = 2'd0,
      UartStart = 2'd1,
      UartData  = 2'd2,
      UartStop  = 2'd3
   } uartState_t;

   // STATUS layout: {16'b0, count[7:0], 4'b0, ovf, full, empty, busy}
   function automatic logic [RegDataWidth-1:0] packStatus(
      input logic [7:0] count,
      input logic       ovf,
      input logic       full,
      input logic       empty,
      input logic       busy
   );
      return {16'b0, count, 4'b0, ovf, full, empty, busy};
   endfunction

endpackage

// File: rtl/mmio_uart_tx_if.sv
// mmio_uart_tx_if
// CPU data-memory port as seen by a memory-mapped peripheral.
//   ce        read enable (mem_re)
//   we        write enable (mem_we)
//   addr_i    byte address
//   byte_slct byte lanes, bit0 = data_i[7:0] ... bit3 = data_i[31:24]
//   data_i    write data
//   data_o    read data, combinational
//   hit       address falls inside the peripheral window, combinational
// master = CPU side, slave = peripheral side.
interface mmio_uart_tx_if;

   logic                                      ce;
   logic                                      we;
   logic [mmio_uart_tx_pkg::MemAddrWidth-1:0] addr_i;
   logic [3:0]                                byte_slct;
   logic [mmio_uart_tx_pkg::RegDataWidth-1:0] data_i;
   logic [mmio_uart_tx_pkg::RegDataWidth-1:0] data_o;
   logic                                      hit;

   modport master (
      output ce, we, addr_i, byte_slct, data_i,
      input  data_o, hit
   );

   modport slave (
      input  ce, we, addr_i, byte_slct, data_i,
      output data_o, hit
   );

endinterface

// File: rtl/mmio_uart_tx_sync_fifo.sv
// sync_fifo
// Single-clock circular FIFO with combinational read data (dout always shows
// the oldest entry). A push while full is accepted only when a pop happens in
// the same cycle; otherwise the push is ignored and the caller flags overflow.
// Ports:
//   clk, rst   clock, asynchronous active-low reset
//   push, din  write request and data
//   pop        read request (ignored while empty)
//   dout       oldest entry
//   count      occupancy 0..DEPTH
//   full/empty occupancy flags
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push,
   input  logic                         pop,
   input  logic [WIDTH-1:0]             din,
   output logic [WIDTH-1:0]             dout,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         full,
   output logic                         empty
);

   localparam int PtrWidth   = $clog2(DEPTH);
   localparam int CountWidth = $clog2(DEPTH + 1);

   logic [WIDTH-1:0]      mem [DEPTH];
   logic [PtrWidth-1:0]   wrPtr;
   logic [PtrWidth-1:0]   rdPtr;
   logic [CountWidth-1:0] fillCount;
   logic                  pushOk;
   logic                  popOk;

   // A full FIFO can still take a byte when the same edge frees a slot:
   // the slot being popped is the one being written, and its old contents
   // have already been read out combinationally.
   assign full   = (fillCount == CountWidth'(DEPTH));
   assign empty  = (fillCount == '0);
   assign pushOk = push && (!full || pop);
   assign popOk  = pop && !empty;
   assign dout   = mem[rdPtr];
   assign count  = fillCount;

   // Storage array has no reset; only the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (pushOk) begin
         mem[wrPtr] <= din;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two; the
   // occupancy count only moves when exactly one of push/pop happens.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wrPtr     <= '0;
         rdPtr     <= '0;
         fillCount <= '0;
      end else begin
         if (pushOk) begin
            wrPtr <= wrPtr + PtrWidth'(1);
         end
         if (popOk) begin
            rdPtr <= rdPtr + PtrWidth'(1);
         end
         case ({pushOk, popOk})
            2'b10:   fillCount <= fillCount + CountWidth'(1);
            2'b01:   fillCount <= fillCount - CountWidth'(1);
            default: fillCount <= fillCount;
         endcase
      end
   end

endmodule

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx
// Memory-mapped 8N1 UART transmitter sitting beside RAM on the CPU
// data-memory port. Stores to TXDATA queue bytes in a TX FIFO; a serializer
// drains them LSB first. Register window (16 bytes at BASE_ADDR):
//   +0 TXDATA  W    byte lane 0 pushes data_i[7:0]; reads 0
//   +4 STATUS  R/W1C {16'b0, count, 4'b0, ovf, full, empty, busy}; data_i[3] clears ovf
//   +8 DIVISOR R/W  bit period = DIVISOR+1 clocks, lanes 0/1
//   +C         reads 0, writes ignored
// Ports:
//   clk   clock, rising edge
//   rst   asynchronous active-low reset
//   bus   CPU data-memory port (slave side); hit gates RAM
//   tx    serial output, idle high
module mmio_uart_tx
   import mmio_uart_tx_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
   parameter int          FIFO_DEPTH = 8,
   parameter logic [15:0] DIV_RESET  = 16'd15
) (
   input  logic           clk,
   input  logic           rst,
   mmio_uart_tx_if.slave  bus,
   output logic           tx
);

   localparam int CountWidth = $clog2(FIFO_DEPTH + 1);

   logic [1:0]            regOffset;
   logic                  txDataWrite;
   logic                  statusWrite;
   logic                  divWrite;
   logic [15:0]           divisor;
   logic [15:0]           baudCnt;
   logic                  baudTick;
   logic                  ovfFlag;
   logic                  busy;
   uartState_t            state;
   logic [2:0]            bitIdx;
   logic [7:0]            shiftReg;
   logic                  fifoPop;
   logic [7:0]            fifoDout;
   logic [CountWidth-1:0] fifoCount;
   logic                  fifoFull;
   logic                  fifoEmpty;
   logic [31:0]           readData;
   logic                  unusedBits;

   // Address decode: the window is 16-byte aligned, so only the upper 28
   // bits identify it and addr[3:2] selects the word register.
   assign bus.hit     = (bus.addr_i[31:4] == BASE_ADDR[31:4]);
   assign regOffset   = bus.addr_i[3:2];
   assign txDataWrite = bus.we && bus.hit && (regOffset == UartTxDataOff) && bus.byte_slct[0];
   assign statusWrite = bus.we && bus.hit && (regOffset == UartStatusOff);
   assign divWrite    = bus.we && bus.hit && (regOffset == UartDivOff);
   assign unusedBits  = ^{bus.addr_i[1:0], bus.data_i[31:16], bus.byte_slct[3:2]};

   // The serializer takes a byte whenever it is ready for a new frame:
   // straight out of IDLE, or at the end of a STOP bit for back-to-back
   // frames. The byte is latched into the shift register on that same edge.
   assign busy     = (state != UartIdle);
   assign baudTick = busy && (baudCnt == divisor);
   assign fifoPop  = !fifoEmpty && ((state == UartIdle) || ((state == UartStop) && baudTick));

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) txFifo (
      .clk   (clk),
      .rst   (rst),
      .push  (txDataWrite),
      .pop   (fifoPop),
      .din   (bus.data_i[7:0]),
      .dout  (fifoDout),
      .count (fifoCount),
      .full  (fifoFull),
      .empty (fifoEmpty)
   );

   // Sticky overflow: a store that the FIFO had to drop sets it, and only a
   // write-one to STATUS bit 3 clears it. A same-cycle pop makes room, so
   // that case is not an overflow.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ovfFlag <= 1'b0;
      end else if (txDataWrite && fifoFull && !fifoPop) begin
         ovfFlag <= 1'b1;
      end else if (statusWrite && bus.byte_slct[0] && bus.data_i[3]) begin
         ovfFlag <= 1'b0;
      end
   end

   // Divisor register, byte-lane writable. The baud compare uses it live,
   // so software should only change it while the transmitter is idle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         divisor <= DIV_RESET;
      end else if (divWrite) begin
         if (bus.byte_slct[0]) begin
            divisor[7:0] <= bus.data_i[7:0];
         end
         if (bus.byte_slct[1]) begin
            divisor[15:8] <= bus.data_i[15:8];
         end
      end
   end

   // Baud counter: parked at zero while idle so every frame starts with a
   // full-length START bit, then counts 0..divisor and restarts on the tick.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         baudCnt <= '0;
      end else if (!busy || baudTick) begin
         baudCnt <= '0;
      end else begin
         baudCnt <= baudCnt + 16'd1;
      end
   end

   // Frame sequencer. tx is registered and updated on the same edge as the
   // state change so the line never glitches. In DATA the next bit to drive
   // is shiftReg[1] because the shift happens on this edge too.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= UartIdle;
         bitIdx   <= '0;
         shiftReg <= '0;
         tx       <= 1'b1;
      end else begin
         case (state)
            UartIdle: begin
               tx <= 1'b1;
               if (!fifoEmpty) begin
                  shiftReg <= fifoDout;
                  state    <= UartStart;
                  tx       <= 1'b0;
               end
            end
            UartStart: begin
               if (baudTick) begin
                  state  <= UartData;
                  bitIdx <= '0;
                  tx     <= shiftReg[0];
               end
            end
            UartData: begin
               if (baudTick) begin
                  if (bitIdx == 3'd7) begin
                     state <= UartStop;
                     tx    <= 1'b1;
                  end else begin
                     shiftReg <= shiftReg >> 1;
                     tx       <= shiftReg[1];
                     bitIdx   <= bitIdx + 3'd1;
                  end
               end
            end
            UartStop: begin
               if (baudTick) begin
                  if (!fifoEmpty) begin
                     shiftReg <= fifoDout;
                     state    <= UartStart;
                     tx       <= 1'b0;
                  end else begin
                     state <= UartIdle;
                     tx    <= 1'b1;
                  end
               end
            end
            default: begin
               state <= UartIdle;
               tx    <= 1'b1;
            end
         endcase
      end
   end

   // Read path is purely combinational so it lines up with RAM reads in the
   // same cycle; nothing here has side effects.
   always_comb begin
      readData = '0;
      if (bus.ce && bus.hit) begin
         case (regOffset)
            UartStatusOff: readData = packStatus(8'(fifoCount), ovfFlag, fifoFull, fifoEmpty, busy);
            UartDivOff:    readData = {16'b0, divisor};
            default:       readData = '0;
         endcase
      end
   end

   assign bus.data_o = readData;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx
// Self-checking bench for mmio_uart_tx. Bytes stored to TXDATA are pushed
// onto a scoreboard queue; a line monitor decodes frames from tx at the
// mid-bit points and pops the queue to compare. Scenario tasks check
// register contents and cycle-exact timing against constants derived from
// the frame format (bit period = div+1, frame = 10 bit periods).
module tb_mmio_uart_tx;
   import mmio_uart_tx_pkg::*;

   localparam logic [31:0] BaseAddr   = 32'h1000_0000;
   localparam logic [31:0] TxDataAddr = BaseAddr;
   localparam logic [31:0] StatusAddr = BaseAddr + 32'd4;
   localparam logic [31:0] DivAddr    = BaseAddr + 32'd8;
   localparam logic [31:0] SpareAddr  = BaseAddr + 32'd12;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic tx;

   mmio_uart_tx_if busIf ();

   mmio_uart_tx #(
      .BASE_ADDR  (BaseAddr),
      .FIFO_DEPTH (8),
      .DIV_RESET  (16'd15)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (busIf),
      .tx  (tx)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int          passCount  = 0;
   int          checkCount = 0;
   logic [7:0]  expQ[$];
   int          curDiv     = 15;
   bit          monEnable  = 1'b0;
   logic [31:0] rdData;
   logic        rdHit;
   int          fullPopEdge;

   // Drives one write cycle starting at a negedge; the write lands on the
   // following posedge and the task returns at the next negedge.
   task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] slct);
      busIf.we        = 1'b1;
      busIf.addr_i    = addr;
      busIf.data_i    = data;
      busIf.byte_slct = slct;
      @(negedge clk);
      busIf.we        = 1'b0;
      busIf.byte_slct = 4'b0;
      busIf.data_i    = '0;
   endtask

   task automatic readRegister(input logic [31:0] addr, input logic ceIn);
      busIf.ce     = ceIn;
      busIf.addr_i = addr;
      #1;
      rdData   = busIf.data_o;
      rdHit    = busIf.hit;
      busIf.ce = 1'b0;
   endtask

   task automatic waitCycle(input int target);
      while (cyc < target) @(negedge clk);
   endtask

   // Line monitor: finds the START bit, samples every bit at its centre,
   // and compares the decoded byte with the oldest scoreboard entry.
   initial begin
      logic [7:0] monByte;
      logic       monStart;
      logic       monStop;
      logic [7:0] monExp;
      int         monD;
      forever begin
         @(negedge clk);
         if (monEnable && rst === 1'b1 && tx === 1'b0) begin
            monD = curDiv + 1;
            repeat (monD / 2) @(negedge clk);
            monStart = tx;
            for (int b = 0; b < 8; b++) begin
               repeat (monD) @(negedge clk);
               monByte[b] = tx;
            end
            repeat (monD) @(negedge clk);
            monStop = tx;
            checkCount++;
            if (monStart !== 1'b0 || monStop !== 1'b1) begin
               $display("[TB] FAIL frame_bits: start=%b stop=%b, required start=0 stop=1", monStart, monStop);
            end else begin
               passCount++;
            end
            checkCount++;
            if (expQ.size() == 0) begin
               $display("[TB] FAIL frame_unexpected: received %h, scoreboard empty", monByte);
            end else begin
               monExp = expQ.pop_front();
               if (monByte !== monExp) begin
                  $display("[TB] FAIL frame_data: received %h, expected %h", monByte, monExp);
               end else begin
                  passCount++;
               end
            end
         end
      end
   end

   task automatic test_reset();
      busIf.ce = 1'b0; busIf.we = 1'b0; busIf.addr_i = '0;
      busIf.data_i = '0; busIf.byte_slct = 4'b0;
      rst = 1'b0;
      repeat (3) @(negedge clk);
      checkCount++;
      if (tx !== 1'b1) $display("[TB] FAIL reset_tx: observed %b, expected 1", tx);
      else passCount++;
      readRegister(StatusAddr, 1'b1);
      checkCount++;
      if (rdData !== 32'h0000_0002) $display("[TB] FAIL reset_status: observed %h, expected 00000002", rdData);
      else passCount++;
      readRegister(DivAddr, 1'b1);
      checkCount++;
      if (rdData !== 32'h0000_000F) $display("[TB] FAIL reset_div: observed %h, expected 0000000f", rdData);
      else passCount++;

      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      applyStimulus(DivAddr, 32'h0000_0007, 4'b0011);
      begin
         int c0;
         c0 = cyc;
         applyStimulus(TxDataAddr, 32'h0000_003C, 4'b0001);
         waitCycle(c0 + 2 + 4);
      end
      readRegister(StatusAddr, 1'b1);
      checkCount++;
      if ({tx, rdData} !== {1'b0, 32'h0000_0003})
         $display("[TB] FAIL midframe_pre_reset: tx=%b status=%h, expected tx=0 status=00000003", tx, rdData);
      else passCount++;

      #1 rst = 1'b0;
      #1;
      checkCount++;
      if (tx !== 1'b1) $display("[TB] FAIL async_reset_tx: observed %b, expected 1", tx);
      else passCount++;
      readRegister(StatusAddr, 1'b1);
      checkCount++;
      if (rdData !== 32'h0000_0002) $display("[TB] FAIL async_reset_status: observed %h, expected 00000002", rdData);
      else passCount++;
      readRegister(DivAddr, 1'b1);
      checkCount++;
      if (rdData !== 32'h0000_000F) $display("[TB] FAIL async_reset_div: observed %h, expected 0000000f", rdData);
      else passCount++;

      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (20) @(negedge clk);
      readRegister(StatusAddr, 1'b1);
      checkCount++;
      if ({tx, rdData} !== {1'b1, 32'h0000_0002})
         $display("[TB] FAIL post_reset_idle: tx=%b status=%h, expected tx=1 status=00000002", tx, rdData);
      else passCount++;
      curDiv    = 15;
      monEnable = 1'b1;
   endtask

   task automatic test_decode();
      applyStimulus(TxDataAddr, 32'h0000_5A5A, 4'b0010);
      repeat (3) @(negedge clk);
      readRegister(StatusAddr, 1'b1);
      checkCount++;
      if ({tx, rdData} !== {1'b1, 32'h0000_0002})
         $display("[TB] FAIL lane1_no_push: tx=%b status=%h, expected tx=1 status=00000002", tx, rdData);
      else passCount++;

      readRegister(BaseAddr + 32'd20, 1'b1);
      checkCount++;
      if ({rdHit, rdData} !== {1'b0, 32'h0})
         $display("[TB] FAIL outside_window: hit=%b data=%h, expected hit=0 data=00000000", rdHit, rdData);
      else passCount++;

      readRegister(StatusAddr, 1'b0);
      checkCount++;
      if ({rdHit, rdData} !== {1'b1, 32'h0})
         $display("[TB] FAIL read_ce_low: hit=%b data=%h, expected hit=1 data=00000000", rdHit, rdData);
      else passCount++;

      readRegister(TxDataAddr, 1'b1);
      checkCount++;
      if (rdData !== 32'h0) $display("[TB] FAIL txdata_read: observed %h, expected 00000000", rdData);
      else passCount++;

      readRegister(SpareAddr, 1'b1);
      checkCount++;
      if (rdData !== 32'h0) $display("[TB] FAIL spare_read: observed %h, expected 00000000", rdData);
      else passCount++;

      applyStimulus(BaseAddr + 32'd16, 32'h0000_0077, 4'b1111);
      repeat (3) @(negedge clk);
      readRegister(StatusAddr, 1'b1);
      checkCount++;
      if ({tx, rdData} !== {1'b1, 32'h0000_0002})
         $display("[TB] FAIL outside_write_no_push: tx=%b status=%h, expected tx=1 status=00000002", tx, rdData);
      else passCount++;

      applyStimulus(DivAddr, 32'h0000_ABCD, 4'b0011);
      readRegister(DivAddr, 1'b1);
      checkCount++;
      if (rdData !== 32'h0000_ABCD) $display("[TB] FAIL div_both_lanes: observed %h, expected 0000abcd", rdData);
      else passCount++;
      applyStimulus(DivAddr, 32'h0000_1200, 4'b0010);
      readRegister(DivAddr, 1'b1);
      checkCount++;
      if (rdData !== 32'h0000_12CD) $display("[TB] FAIL div_lane1: observed %h, expected 000012cd", rdData);
      else passCount++;
      applyStimulus(DivAddr, 32'hFFFF_0034, 4'b1101);
      readRegister(DivAddr, 1'b1);
      checkCount++;
      if (rdData !== 32'h0000_1234) $display("[TB] FAIL div_lane0: observed %h, expected 00001234", rdData);
      else passCount++;

      busIf.ce = 1'b1; busIf.we = 1'b1; busIf.addr_i = DivAddr;
      busIf.data_i = 32'h0000_000F; busIf.byte_slct = 4'b0011;
      #1;
      checkCount++;
      if (busIf.data_o !== 32'h0000_1234)
         $display("[TB] FAIL read_during_write_pre: observed %h, expected 00001234", busIf.data_o);
      else passCount++;
      @(negedge clk);
      busIf.we = 1'b0; busIf.byte_slct = 4'b0;
      #1;
      checkCount++;
      if (busIf.data_o !== 32'h0000_000F)
         $display("[TB] FAIL read_during_write_post: observed %h, expected 0000000f", busIf.data_o);
      else passCount++;
      busIf.ce = 1'b0;
      curDiv = 15;
      @(negedge clk);
   endtask

   task automatic test_single_byte();
      logic [9:0]  frameBits;
      logic [39:0] obs;
      logic [39:0] expv;
      int          c0;
      int          e;
      applyStimulus(DivAddr, 32'h0000_0003, 4'b0011);
      curDiv = 3;
      frameBits = {1'b1, 8'hA5, 1'b0};
      for (int i = 0; i < 40; i++) expv[i] = frameBits[i / 4];
      c0 = cyc;
      expQ.push_back(8'hA5);
      applyStimulus(TxDataAddr, 32'h0000_00A5, 4'b0001);
      e = c0 + 2;
      for (int i = 0; i < 40; i++) begin
         waitCycle(e + i);
         obs[i] = tx;
      end
      checkCount++;
      if (obs !== expv) $display("[TB] FAIL single_byte_waveform: observed %h, expected %h", obs, expv);
      else passCount++;
      readRegister(StatusAddr, 1'b1);
      checkCount++;
      if (rdData !== 32'h0000_0003) $display("[TB] FAIL single_busy_last: observed %h, expected 00000003", rdData);
      else passCount++;
      waitCycle(e + 40);
      readRegister(StatusAddr, 1'b1);
      checkCount++;
      if (rdData !== 32'h0000_0002) $display("[TB] FAIL single_busy_clear: observed %h, expected 00000002", rdData);
      else passCount++;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_back_to_back();
      int          c0;
      int          e0;
      int          ek;
      logic        txBefore;
      logic [31:0] expStatus;
      c0 = cyc;
      expQ.push_back(8'h33);
      expQ.push_back(8'h55);
      expQ.push_back(8'h0F);
      expQ.push_back(8'hFF);
      applyStimulus(TxDataAddr, 32'h0000_0033, 4'b0001);
      applyStimulus(TxDataAddr, 32'h0000_0055, 4'b0001);
      applyStimulus(TxDataAddr, 32'h0000_000F, 4'b0001);
      applyStimulus(TxDataAddr, 32'h0000_00FF, 4'b0001);
      e0 = c0 + 2;
      readRegister(StatusAddr, 1'b1);
      checkCount++;
      if (rdData !== 32'h0000_0301) $display("[TB] FAIL b2b_count3: observed %h, expected 00000301", rdData);
      else passCount++;
      for (int k = 1; k <= 3; k++) begin
         ek = e0 + 40 * k;
         waitCycle(ek - 1);
         txBefore = tx;
         waitCycle(ek);
         checkCount++;
         if ({txBefore, tx} !== 2'b10)
            $display("[TB] FAIL b2b_no_gap_%0d: stop/start=%b%b, expected 10", k, txBefore, tx);
         else passCount++;
         readRegister(StatusAddr, 1'b1);
         expStatus = {16'b0, 8'(3 - k), 4'b0, 1'b0, 1'b0, (k == 3), 1'b1};
         checkCount++;
         if (rdData !== expStatus) $display("[TB] FAIL b2b_count_%0d: observed %h, expected %h", k, rdData, expStatus);
         else passCount++;
      end
      waitCycle(e0 + 159);
      readRegister(StatusAddr, 1'b1);
      checkCount++;
      if (rdData !== 32'h0000_0003) $display("[TB] FAIL b2b_busy_last: observed %h, expected 00000003", rdData);
      else passCount++;
      waitCycle(e0 + 160);
      readRegister(StatusAddr, 1'b1);
      checkCount++;
      if ({tx, rdData} !== {1'b1, 32'h0000_0002})
         $display("[TB] FAIL b2b_idle: tx=%b status=%h, expected tx=1 status=00000002", tx, rdData);
      else passCount++;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_overflow();
      int c0;
      applyStimulus(DivAddr, 32'h0000_000F, 4'b0011);
      curDiv = 15;
      c0 = cyc;
      for (int i = 0; i < 10; i++) begin
         if (i <= 8) expQ.push_back(8'hB0 + 8'(i));
         applyStimulus(TxDataAddr, 32'h0000_00B0 + 32'(i), 4'b0001);
      end
      fullPopEdge = c0 + 2 + 160;
      readRegister(StatusAddr, 1'b1);
      checkCount++;
      if (rdData !== 32'h0000_080D) $display("[TB] FAIL ovf_set: observed %h, expected 0000080d", rdData);
      else passCount++;
      applyStimulus(StatusAddr, 32'h0000_0007, 4'b0001);
      readRegister(StatusAddr, 1'b1);
      checkCount++;
      if (rdData !== 32'h0000_080D) $display("[TB] FAIL ovf_keep_without_bit3: observed %h, expected 0000080d", rdData);
      else passCount++;
      applyStimulus(StatusAddr, 32'h0000_0008, 4'b0001);
      readRegister(StatusAddr, 1'b1);
      checkCount++;
      if (rdData !== 32'h0000_0805) $display("[TB] FAIL ovf_clear: observed %h, expected 00000805", rdData);
      else passCount++;
   endtask

   task automatic test_full_pop();
      waitCycle(fullPopEdge - 1);
      expQ.push_back(8'hEE);
      applyStimulus(TxDataAddr, 32'h0000_00EE, 4'b0001);
      readRegister(StatusAddr, 1'b1);
      checkCount++;
      if ({tx, rdData} !== {1'b0, 32'h0000_0805})
         $display("[TB] FAIL full_push_pop: tx=%b status=%h, expected tx=0 status=00000805", tx, rdData);
      else passCount++;
   endtask

   task automatic test_drain();
      for (int i = 0; i < 3000 && expQ.size() != 0; i++) @(negedge clk);
      checkCount++;
      if (expQ.size() != 0) $display("[TB] FAIL drain: %0d bytes never seen, expected 0", expQ.size());
      else passCount++;
      repeat (40) @(negedge clk);
      readRegister(StatusAddr, 1'b1);
      checkCount++;
      if ({tx, rdData} !== {1'b1, 32'h0000_0002})
         $display("[TB] FAIL drain_idle: tx=%b status=%h, expected tx=1 status=00000002", tx, rdData);
      else passCount++;
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      test_reset();
      test_decode();
      test_single_byte();
      test_back_to_back();
      test_overflow();
      test_full_pop();
      test_drain();
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
